// File: rtl/ctr_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctr_buffer_ctrl_pkg
// Shared types for the control-transfer-record (CTR) buffer controller:
//   - core configuration struct and its empty default
//   - privilege level, transfer type and record source/target types
//   - the buffer state enum and the stored record struct
//   - a helper mapping a privilege level onto its recording-enable bit
// -----------------------------------------------------------------------------
package ctr_buffer_ctrl_pkg;

  // Record PCs are stored without bit 0, so they are XLEN-1 bits wide.
  localparam int unsigned CtrXlen = 64;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t CtrCfgEmpty = '{XLEN: CtrXlen};

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef logic [3:0] ctr_type_t;

  typedef struct packed {
    logic [CtrXlen-2:0] pc;
    logic               v;
  } ctrsource_rv_t;

  typedef struct packed {
    logic [CtrXlen-2:0] pc;
    logic               misp;
  } ctrtarget_rv_t;

  typedef struct packed {
    ctrsource_rv_t source;
    ctrtarget_rv_t target;
    ctr_type_t     data;
  } ctr_record_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FROZEN = 2'd1,
    CLEAR  = 2'd2
  } ctr_buf_state_e;

  // Enable bits are ordered U, S, M; the reserved level 2 never records.
  function automatic logic priv_enabled(input priv_lvl_t lvl, input logic [2:0] en);
    case (lvl)
      PRIV_LVL_U: return en[0];
      PRIV_LVL_S: return en[1];
      PRIV_LVL_M: return en[2];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctr_buffer_ctrl_ram.sv
// -----------------------------------------------------------------------------
// ctr_record_ram
// Flop-based record storage, NrEntries deep, one synchronous write port and
// one asynchronous read port. Synchronous active-low reset zeroes every entry.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   we_i/waddr_i/wdata_i  write enable, address, record
//   raddr_i/rdata_o    combinational read address and record
// -----------------------------------------------------------------------------
module ctr_record_ram
  import ctr_buffer_ctrl_pkg::*;
#(
  parameter int unsigned NrEntries = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [$clog2(NrEntries)-1:0] waddr_i,
  input  ctr_record_t                  wdata_i,
  input  logic [$clog2(NrEntries)-1:0] raddr_i,
  output ctr_record_t                  rdata_o
);

  ctr_record_t r_mem [NrEntries];

  // Reset clears every entry so that an unwritten slot reads back as invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrEntries); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/ctr_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// ctr_buffer_ctrl
// Circular control-transfer-record buffer with privilege/type filtering,
// freeze and an entry-by-entry clear sequence.
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   emit_source_i/target_i/data_i   emitted record (source.v qualifies it)
//   priv_lvl_i                      privilege level of the emitted record
//   cfg_priv_en_i, cfg_type_inh_i   privilege enables (U,S,M) / type inhibits
//   freeze_i, unfreeze_i            freeze control pulses
//   clear_req_i                     buffer clear pulse
//   wrptr_we_i, wrptr_wdata_i       CSR write of the write pointer
//   rd_idx_i -> rd_*_o              logical read (0 = newest), combinational
//   wrptr_o, frozen_o, clear_busy_o status
//   drop_o                          valid record lost to freeze or clear
// -----------------------------------------------------------------------------
module ctr_buffer_ctrl
  import ctr_buffer_ctrl_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg   = CtrCfgEmpty,
  parameter int unsigned NrEntries = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  ctrsource_rv_t                     emit_source_i,
  input  ctrtarget_rv_t                     emit_target_i,
  input  ctr_type_t                         emit_data_i,
  input  priv_lvl_t                         priv_lvl_i,
  input  logic [2:0]                        cfg_priv_en_i,
  input  logic [2**$bits(ctr_type_t)-1:0]   cfg_type_inh_i,
  input  logic                              freeze_i,
  input  logic                              unfreeze_i,
  input  logic                              clear_req_i,
  input  logic                              wrptr_we_i,
  input  logic [$clog2(NrEntries)-1:0]      wrptr_wdata_i,
  input  logic [$clog2(NrEntries)-1:0]      rd_idx_i,
  output ctrsource_rv_t                     rd_source_o,
  output ctrtarget_rv_t                     rd_target_o,
  output ctr_type_t                         rd_data_o,
  output logic [$clog2(NrEntries)-1:0]      wrptr_o,
  output logic                              frozen_o,
  output logic                              clear_busy_o,
  output logic                              drop_o
);

  localparam int unsigned IdxW = $clog2(NrEntries);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrEntries - 1);

  // Record layout is fixed by the package, so the core XLEN must agree with it.
  if (CVA6Cfg.XLEN != CtrXlen) begin : gen_xlen_check
    $error("ctr_buffer_ctrl: CVA6Cfg.XLEN does not match the record PC width");
  end
  if (NrEntries < 2 || NrEntries > 256 || (2 ** IdxW) != NrEntries) begin : gen_depth_check
    $error("ctr_buffer_ctrl: NrEntries must be a power of 2 from 2 to 256");
  end

  ctr_buf_state_e  r_state, w_state_nxt;
  logic [IdxW-1:0] r_wrptr, w_wrptr_nxt;
  logic [IdxW-1:0] r_clr_cnt, w_clr_cnt_nxt;
  logic            r_freeze_pend, w_freeze_pend_nxt;

  logic            w_valid, w_accept;
  logic            w_ram_we;
  logic [IdxW-1:0] w_ram_waddr, w_rd_phys;
  ctr_record_t     w_ram_wdata, w_rd_rec;

  assign w_valid  = emit_source_i.v;
  assign w_accept = w_valid && (r_state == RUN)
                  && priv_enabled(priv_lvl_i, cfg_priv_en_i)
                  && !cfg_type_inh_i[emit_data_i];

  // Next-state logic. Outside CLEAR a CSR pointer write overrides the accept
  // increment (the record still lands at the old pointer), and a clear request
  // overrides everything. Inside CLEAR a freeze pulse is remembered so the
  // sequence can finish into FROZEN instead of RUN.
  always_comb begin
    w_state_nxt       = r_state;
    w_wrptr_nxt       = r_wrptr;
    w_clr_cnt_nxt     = r_clr_cnt;
    w_freeze_pend_nxt = r_freeze_pend;
    case (r_state)
      RUN, FROZEN: begin
        if (w_accept)   w_wrptr_nxt = r_wrptr + 1'b1;
        if (wrptr_we_i) w_wrptr_nxt = wrptr_wdata_i;
        if (clear_req_i) begin
          w_state_nxt       = CLEAR;
          w_wrptr_nxt       = '0;
          w_clr_cnt_nxt     = '0;
          w_freeze_pend_nxt = 1'b0;
        end else if ((r_state == RUN) && freeze_i) begin
          w_state_nxt = FROZEN;
        end else if ((r_state == FROZEN) && unfreeze_i && !freeze_i) begin
          w_state_nxt = RUN;
        end
      end
      CLEAR: begin
        w_freeze_pend_nxt = r_freeze_pend | freeze_i;
        if (clear_req_i) begin
          w_clr_cnt_nxt = '0;
        end else if (r_clr_cnt == LastIdx) begin
          w_state_nxt       = (r_freeze_pend | freeze_i) ? FROZEN : RUN;
          w_clr_cnt_nxt     = '0;
          w_freeze_pend_nxt = 1'b0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State registers; reset wins over any in-flight clear sequence.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= RUN;
      r_wrptr       <= '0;
      r_clr_cnt     <= '0;
      r_freeze_pend <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wrptr       <= w_wrptr_nxt;
      r_clr_cnt     <= w_clr_cnt_nxt;
      r_freeze_pend <= w_freeze_pend_nxt;
    end
  end

  // The single write port is shared: CLEAR zeroes the entry under the counter,
  // otherwise an accepted record goes to the current write pointer.
  always_comb begin
    w_ram_we    = w_accept;
    w_ram_waddr = r_wrptr;
    w_ram_wdata = '{source: emit_source_i, target: emit_target_i, data: emit_data_i};
    if (r_state == CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_clr_cnt;
      w_ram_wdata = '0;
    end
  end

  // Logical index 0 is the slot just behind the write pointer (newest record).
  assign w_rd_phys = r_wrptr - 1'b1 - rd_idx_i;

  ctr_record_ram #(
    .NrEntries (NrEntries)
  ) i_ctr_record_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (w_ram_we),
    .waddr_i (w_ram_waddr),
    .wdata_i (w_ram_wdata),
    .raddr_i (w_rd_phys),
    .rdata_o (w_rd_rec)
  );

  // Outputs are forced quiet while reset is held.
  assign rd_source_o  = rst_ni ? w_rd_rec.source : '0;
  assign rd_target_o  = rst_ni ? w_rd_rec.target : '0;
  assign rd_data_o    = rst_ni ? w_rd_rec.data   : '0;
  assign wrptr_o      = r_wrptr;
  assign frozen_o     = rst_ni && (r_state == FROZEN);
  assign clear_busy_o = rst_ni && (r_state == CLEAR);
  assign drop_o       = rst_ni && w_valid && (r_state != RUN);

endmodule

// File: doc/ctr_buffer_ctrl.md
CTR_BUFFER_CTRL -- requirements
Module: ctr_buffer_ctrl

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 Parameter NrEntries, default 16, record buffer depth; legal values are powers of 2 from 2 to 256.
REQ-003 clk_i  in  1  single core clock.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 emit_source_i  in  ctrsource_rv_t  emitted record source; its v field is the record-valid qualifier.
REQ-006 emit_target_i  in  ctrtarget_rv_t  emitted record target.
REQ-007 emit_data_i  in  ctr_type_t  emitted record transfer type.
REQ-008 priv_lvl_i  in  priv_lvl_t  privilege level of the emitted record.
REQ-009 cfg_priv_en_i  in  3  recording enable per privilege level: bit0 U, bit1 S, bit2 M.
REQ-010 cfg_type_inh_i  in  2^$bits(ctr_type_t)  per-type inhibit mask; a set bit drops that type.
REQ-011 freeze_i  in  1  single-cycle pulse requesting freeze.
REQ-012 unfreeze_i  in  1  single-cycle pulse releasing freeze.
REQ-013 clear_req_i  in  1  single-cycle pulse requesting a buffer clear.
REQ-014 wrptr_we_i / wrptr_wdata_i  in  1 / log2(NrEntries)  CSR write of the write pointer.
REQ-015 rd_idx_i  in  log2(NrEntries)  logical read index; 0 is the newest record.
REQ-016 rd_source_o / rd_target_o / rd_data_o  out  record types  combinational read data.
REQ-017 wrptr_o  out  log2(NrEntries)  current write pointer.
REQ-018 frozen_o  out  1  buffer is frozen.
REQ-019 clear_busy_o  out  1  a clear is in progress.
REQ-020 drop_o  out  1  one-cycle pulse when a valid record is discarded because of freeze or clear.

Function
REQ-021 The state machine has three states: RUN, FROZEN and CLEAR.
REQ-022 A record is accepted only when all of the following hold:
- emit_source_i.v is 1;
- state is RUN;
- cfg_priv_en_i bit for priv_lvl_i is set (U=0, S=1, M=3; any other level maps to no bit and is dropped);
- cfg_type_inh_i[emit_data_i] is 0.
REQ-023 Accepted record handling:
- written to physical entry wrptr at the next clock edge;
- wrptr increments modulo NrEntries in the same edge;
- wrap-around overwrites the oldest entry silently.
REQ-024 A record filtered by priv or type is discarded without asserting drop_o.
REQ-025 A valid record arriving in FROZEN or CLEAR asserts drop_o in that cycle and is discarded.
REQ-026 Read mapping: physical = (wrptr - 1 - rd_idx_i) mod NrEntries; read output is combinational, zero latency.
REQ-027 A record written in cycle N is readable at rd_idx_i=0 in cycle N+1.
REQ-028 Transition RUN->FROZEN on freeze_i.
REQ-029 Transition FROZEN->RUN on unfreeze_i.
REQ-030 freeze_i in FROZEN has no effect; unfreeze_i in RUN has no effect.
REQ-031 If freeze_i and unfreeze_i are asserted together, freeze_i wins.
REQ-032 Transition RUN/FROZEN->CLEAR on clear_req_i; clear_req_i has priority over freeze_i and unfreeze_i.
REQ-033 CLEAR sequence:
- zero one entry per cycle, 0 to NrEntries-1, using an internal counter;
- this takes exactly NrEntries cycles;
- clear_busy_o=1 throughout;
- wrptr is set to 0;
- then go to RUN, or to FROZEN if a freeze_i pulse occurred during CLEAR.
REQ-034 clear_req_i during CLEAR restarts the counter at 0.
REQ-035 wrptr_we_i in any state other than CLEAR loads wrptr_wdata_i and leaves entries unchanged; it is ignored during CLEAR.
REQ-036 If wrptr_we_i and a record accept fall in the same cycle, the record is written at the old wrptr and wrptr takes wrptr_wdata_i.
REQ-037 frozen_o = (state == FROZEN); clear_busy_o = (state == CLEAR).

Reset
REQ-038 When rst_ni=0 at a clock edge, the block shall:
- enter RUN;
- set wrptr=0 and the clear counter to 0;
- zero all entries (source.v=0).
REQ-039 During and after reset, outputs are:
- frozen_o=0, clear_busy_o=0, drop_o=0;
- rd_*_o all zero.
REQ-040 Reset asserted mid-CLEAR aborts the clear, applies the reset values of REQ-038, and takes priority over every other input.

Structure
REQ-041 A ctr_buf_state_e enum (RUN, FROZEN, CLEAR) and the ctr_record_t struct (source, target, data) are added to ariane_pkg.
REQ-042 The record storage shall be a sub-module ctr_record_ram: one write port, one asynchronous read port, flop-based, NrEntries deep, with synchronous reset.

Verification
REQ-043 Reset, then 3 accepted M-mode records (cfg_priv_en_i=3'b100): wrptr_o=3, and rd_idx_i=0 returns the third record.
REQ-044 NrEntries=16, 18 accepted records: wrptr_o=2; rd_idx_i=15 returns record #3; record #1 is unreadable.
REQ-045 cfg_type_inh_i bit for the emitted type set, or priv_lvl_i=U with cfg_priv_en_i[0]=0: wrptr unchanged and drop_o=0.
REQ-046 freeze_i, then 2 valid records, then unfreeze_i:
- drop_o pulses twice;
- wrptr is unchanged;
- the next record is accepted.
REQ-047 clear_req_i with freeze_i pulsed during CLEAR:
- clear_busy_o is high for exactly 16 cycles;
- all reads return 0 and wrptr_o=0;
- the final state is FROZEN.
REQ-048 Reset pulsed in CLEAR cycle 5: the next cycle shows state RUN and clear_busy_o=0.
